// File: rtl/bit_sample_ctrl_if.sv
// bit_sample_ctrl_if: control bus (master drives transEn/tick; slave returns srClock, bitIdx, busy, frameDone)
interface bit_sample_ctrl_if #(parameter int BW = 4);
  logic          transEn;
  logic          tick;
  logic          srClock;
  logic [BW-1:0] bitIdx;
  logic          busy;
  logic          frameDone;
  modport master (output transEn, tick, input srClock, bitIdx, busy, frameDone);
  modport slave (input transEn, tick, output srClock, bitIdx, busy, frameDone);
endinterface

// File: rtl/bit_sample_ctrl.sv
// bit_sample_ctrl: per-bit sample strobe and frame tracker; ports clk, rst (sync active-low), bus (slave: transEn/tick in, srClock/bitIdx/busy/frameDone out)
module bit_sample_ctrl #(
  parameter int OSR        = 16,
  parameter int SAMPLE_PT  = 7,
  parameter int FRAME_BITS = 10
) (
  input  logic               clk,
  input  logic               rst,
  bit_sample_ctrl_if.slave   bus
);
  localparam int SW = ($clog2(OSR) > 1) ? $clog2(OSR) : 1;
  localparam int BW = ($clog2(FRAME_BITS) > 1) ? $clog2(FRAME_BITS) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t        r_state;
  logic [SW-1:0] r_scnt;
  logic [BW-1:0] r_bcnt;
  logic          w_run;
  logic          w_s_last;
  logic          w_b_last;
  assign w_run    = r_state == RUN;
  assign w_s_last = r_scnt == SW'(OSR - 1);
  assign w_b_last = r_bcnt == BW'(FRAME_BITS - 1);
  always_ff @(posedge clk)
    if (!rst) begin
      r_state <= IDLE;
      r_scnt  <= '0;
      r_bcnt  <= '0;
    end else if (!w_run || !bus.transEn) begin
      r_state <= bus.transEn ? RUN : IDLE;
      r_scnt  <= '0;
      r_bcnt  <= '0;
    end else if (bus.tick) begin
      r_scnt <= w_s_last ? '0 : r_scnt + 1'b1;
      r_bcnt <= w_s_last ? (w_b_last ? '0 : r_bcnt + 1'b1) : r_bcnt;
    end
  assign bus.srClock   = w_run & bus.tick & (r_scnt == SW'(SAMPLE_PT));
  assign bus.frameDone = w_run & bus.tick & w_s_last & w_b_last;
  assign bus.busy      = w_run;
  assign bus.bitIdx    = r_bcnt;
endmodule
